// File: rtl/spi_master_ctrl.sv
// SPI mode-0 initiator, MSB first, one fixed-length full-duplex packet per request.
// Optional recv_parity output is enabled with `define SPI_MASTER_CTRL_PARITY_EN.
module spi_master_ctrl #(
  parameter int NBITS   = 20,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send_val,
  output logic             send_rdy,
  input  logic [NBITS-1:0] send_msg,
  output logic             recv_val,
  input  logic             recv_rdy,
  output logic [NBITS-1:0] recv_msg,
  output logic             cs,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
`ifdef SPI_MASTER_CTRL_PARITY_EN
  ,
  output logic             recv_parity
`endif
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(NBITS + 1);

  typedef enum logic [2:0] {GAP, IDLE, SETUP, HIGH, LOW, DONE} state_t;

  state_t           state;
  logic [PW-1:0]    phase_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [NBITS-1:0] tx;
  logic [NBITS-1:0] rx;

  logic             phase_end;
  logic [NBITS-1:0] tx_shift;
  logic [NBITS-1:0] rx_shift;

  // The cast keeps the shift legal for NBITS == 1.
  always_comb begin
    phase_end = (phase_cnt == PW'(1));
    tx_shift  = tx << 1;
    rx_shift  = NBITS'({rx, miso});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= GAP;
      phase_cnt <= PW'(CLK_DIV);
      bit_cnt   <= '0;
      tx        <= '0;
      rx        <= '0;
      cs        <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      send_rdy  <= 1'b0;
      recv_val  <= 1'b0;
      recv_msg  <= '0;
`ifdef SPI_MASTER_CTRL_PARITY_EN
      recv_parity <= 1'b0;
`endif
    end else begin
      case (state)
        GAP: begin
          if (phase_end) begin
            state    <= IDLE;
            send_rdy <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end
        IDLE: begin
          if (send_val && send_rdy) begin
            state     <= SETUP;
            send_rdy  <= 1'b0;
            tx        <= send_msg;
            bit_cnt   <= BW'(NBITS);
            phase_cnt <= PW'(CLK_DIV);
            cs        <= 1'b0;
            mosi      <= send_msg[NBITS-1];
          end
        end
        SETUP: begin
          if (phase_end) begin
            state     <= HIGH;
            sclk      <= 1'b1;
            phase_cnt <= PW'(CLK_DIV);
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end
        HIGH: begin
          if (phase_end) begin
            state     <= LOW;
            rx        <= rx_shift;
            tx        <= tx_shift;
            bit_cnt   <= bit_cnt - BW'(1);
            sclk      <= 1'b0;
            mosi      <= tx_shift[NBITS-1];
            phase_cnt <= PW'(CLK_DIV);
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end
        LOW: begin
          // Last LOW phase doubles as cs hold time; mosi is already 0 from the zero-filled tx.
          if (phase_end) begin
            phase_cnt <= PW'(CLK_DIV);
            if (bit_cnt != '0) begin
              state <= HIGH;
              sclk  <= 1'b1;
            end else begin
              state    <= DONE;
              cs       <= 1'b1;
              mosi     <= 1'b0;
              recv_val <= 1'b1;
              recv_msg <= rx;
`ifdef SPI_MASTER_CTRL_PARITY_EN
              recv_parity <= ^rx;
`endif
            end
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end
        DONE: begin
          if (recv_rdy) begin
            state     <= GAP;
            recv_val  <= 1'b0;
            phase_cnt <= PW'(CLK_DIV);
          end
        end
        default: begin
          state     <= GAP;
          phase_cnt <= PW'(CLK_DIV);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl (NBITS=8, CLK_DIV=2): vector table plus
// randomized entries against a behavioural reply model, and hand-written corner sequences.
module tb_spi_master_ctrl;

  localparam int NB     = 8;
  localparam int CD     = 2;
  localparam int CS_LOW = CD * (2 * NB + 1);
  localparam int NVEC   = 12;

  // miso source selection
  localparam int unsigned M_LOOP = 0;
  localparam int unsigned M_TIE0 = 1;
  localparam int unsigned M_TIE1 = 2;
  localparam int unsigned M_PAT  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          send_val;
  logic          send_rdy;
  logic [NB-1:0] send_msg;
  logic          recv_val;
  logic          recv_rdy;
  logic [NB-1:0] recv_msg;
  logic          cs;
  logic          sclk;
  logic          mosi;
  logic          miso;
`ifdef SPI_MASTER_CTRL_PARITY_EN
  logic          recv_parity;
`endif

  spi_master_ctrl #(.NBITS(NB), .CLK_DIV(CD)) dut (
    .clk      (clk),
    .reset    (reset),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg),
    .cs       (cs),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso)
`ifdef SPI_MASTER_CTRL_PARITY_EN
    ,
    .recv_parity (recv_parity)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  typedef struct {
    logic [NB-1:0] msg;
    int unsigned   mode;
    logic [NB-1:0] word;
    int unsigned   hold;
    logic [NB-1:0] exp_reply;
  } vec_t;

  vec_t vecs[NVEC];

  // Reply model: the minion's bits, MSB first, whatever the miso source is.
  function automatic logic [NB-1:0] ref_reply(input logic [NB-1:0] msg, input int unsigned mode,
                                              input logic [NB-1:0] word);
    case (mode)
      M_LOOP:  return msg;
      M_TIE0:  return '0;
      M_TIE1:  return '1;
      default: return word;
    endcase
  endfunction

  // miso driving
  int unsigned   mode = M_LOOP;
  logic [NB-1:0] rand_word = '0;
  logic          pat_bit = 1'b0;
  assign miso = (mode == M_LOOP) ? mosi :
                (mode == M_TIE0) ? 1'b0 :
                (mode == M_TIE1) ? 1'b1 : pat_bit;

  // Bus monitor, sampled on the falling clock edge.
  logic          prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  int            cs_low_cnt = 0, cs_high_run = 0, last_cs_low = 0, last_gap = 0;
  int            rise_cnt = 0, hi_run = 0, fall_idx = 0;
  logic [NB-1:0] mosi_word = '0;
  logic          hi_bad = 1'b0, mosi_unstable = 1'b0, seen_one = 1'b0, rv_at_rise = 1'b0;
  logic [NB-1:0] got_q[$];

  always @(negedge clk) begin
    if (prev_cs && !cs) begin
      last_gap      = cs_high_run;
      cs_low_cnt    = 0;
      rise_cnt      = 0;
      mosi_word     = '0;
      hi_bad        = 1'b0;
      mosi_unstable = 1'b0;
      seen_one      = 1'b0;
      fall_idx      = 0;
    end
    if (!cs) begin
      cs_low_cnt++;
      cs_high_run = 0;
      if (mosi) seen_one = 1'b1;
    end else begin
      cs_high_run++;
    end
    if (sclk && !prev_sclk && !cs) begin
      rise_cnt++;
      mosi_word = {mosi_word[NB-2:0], mosi};
    end
    if (sclk) hi_run++;
    if (!sclk && prev_sclk) begin
      if (hi_run != CD) hi_bad = 1'b1;
      hi_run = 0;
      fall_idx++;
    end
    if (sclk && prev_sclk && (mosi != prev_mosi)) mosi_unstable = 1'b1;
    if (cs)                 pat_bit = rand_word[NB-1];
    else if (fall_idx < NB) pat_bit = rand_word[NB-1-fall_idx];
    else                    pat_bit = 1'b0;
    if (!prev_cs && cs) begin
      last_cs_low = cs_low_cnt;
      rv_at_rise  = recv_val;
    end
    if (recv_val && recv_rdy) got_q.push_back(recv_msg);
    prev_cs   = cs;
    prev_sclk = sclk;
    prev_mosi = mosi;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until send_rdy is seen; returns -1 on timeout.
  task automatic wait_send_rdy(output int n);
    n = -1;
    for (int i = 0; i < 200; i++) begin
      if (send_rdy) begin
        n = i;
        break;
      end
      tick();
    end
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    int  n;
    bit  stable;
    logic [NB-1:0] held;
    wait_send_rdy(n);
    check({tag, "_rdy_timeout"}, (n >= 0), 1);
    mode      = v.mode;
    rand_word = v.word;
    send_msg  = v.msg;
    send_val  = 1'b1;
    tick();
    send_val = 1'b0;
    send_msg = NB'($urandom);
    check({tag, "_cs_after_accept"}, cs, 0);
    n = -1;
    for (int i = 0; i < 200; i++) begin
      if (recv_val) begin
        n = i;
        break;
      end
      tick();
    end
    check({tag, "_recv_timeout"}, (n >= 0), 1);
    @(negedge clk);
    #1;
    check({tag, "_recv_msg"}, recv_msg, v.exp_reply);
    check({tag, "_cs_low_len"}, last_cs_low, CS_LOW);
    check({tag, "_sclk_rises"}, rise_cnt, NB);
    check({tag, "_mosi_bits"}, mosi_word, v.msg);
    check({tag, "_sclk_high_width"}, hi_bad, 0);
    check({tag, "_mosi_stable_high"}, mosi_unstable, 0);
    check({tag, "_mosi_any_one"}, seen_one, (v.msg != '0));
    check({tag, "_rv_with_cs_rise"}, rv_at_rise, 1);
`ifdef SPI_MASTER_CTRL_PARITY_EN
    check({tag, "_parity"}, recv_parity, ^v.exp_reply);
`endif
    held   = recv_msg;
    stable = 1'b1;
    for (int unsigned c = 0; c < v.hold; c++) begin
      tick();
      if (!recv_val || recv_msg != held || send_rdy || !cs || sclk) stable = 1'b0;
    end
    check({tag, "_backpressure_hold"}, stable, 1);
    recv_rdy = 1'b1;
    tick();
    recv_rdy = 1'b0;
    check({tag, "_recv_val_drop"}, recv_val, 0);
    // send_rdy returns CLK_DIV edges after the accepting edge (CLK_DIV+1 cycles counting the accept cycle).
    n = -1;
    for (int i = 1; i < 40; i++) begin
      tick();
      if (send_rdy) begin
        n = i;
        break;
      end
    end
    check({tag, "_send_rdy_return"}, n, CD);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    int  rises;
    bit  quiet;
    logic prev;
    vec_t v;

    vecs[0] = '{msg: 8'hA5, mode: M_LOOP, word: 8'h00, hold: 0,  exp_reply: 8'hA5};
    vecs[1] = '{msg: 8'h00, mode: M_TIE1, word: 8'h00, hold: 0,  exp_reply: 8'hFF};
    vecs[2] = '{msg: 8'hFF, mode: M_TIE0, word: 8'h00, hold: 10, exp_reply: 8'h00};
    vecs[3] = '{msg: 8'h07, mode: M_LOOP, word: 8'h00, hold: 2,  exp_reply: 8'h07};
    vecs[4] = '{msg: 8'h03, mode: M_LOOP, word: 8'h00, hold: 0,  exp_reply: 8'h03};
    for (int i = 5; i < NVEC; i++) begin
      vecs[i].msg       = NB'($urandom);
      vecs[i].mode      = $urandom_range(0, 3);
      vecs[i].word      = NB'($urandom);
      vecs[i].hold      = $urandom_range(0, 4);
      vecs[i].exp_reply = ref_reply(vecs[i].msg, vecs[i].mode, vecs[i].word);
    end

    // Reset with send_val asserted: nothing may start.
    reset    = 1'b1;
    send_val = 1'b1;
    send_msg = 8'hFF;
    recv_rdy = 1'b0;
    tick();
    tick();
    tick();
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_send_rdy", send_rdy, 0);
    check("rst_recv_val", recv_val, 0);
    check("rst_recv_msg", recv_msg, 0);
`ifdef SPI_MASTER_CTRL_PARITY_EN
    check("rst_parity", recv_parity, 0);
`endif
    send_val = 1'b0;
    reset    = 1'b0;
    wait_send_rdy(n);
    check("rst_gap_len", n, CD);

    foreach (vecs[i]) begin
      v = vecs[i];
      do_txn(v, $sformatf("vec%0d", i));
    end

    // Back-to-back with send_val held and recv_rdy high.
    got_q.delete();
    mode     = M_LOOP;
    recv_rdy = 1'b1;
    send_val = 1'b1;
    send_msg = 8'h3C;
    wait_send_rdy(n);
    check("b2b_first_rdy", (n >= 0), 1);
    tick();
    send_msg = 8'hC3;
    tick();
    wait_send_rdy(n);
    check("b2b_second_rdy", (n >= 0), 1);
    tick();
    send_val = 1'b0;
    for (int i = 0; i < 200 && got_q.size() < 2; i++) tick();
    check("b2b_reply_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("b2b_reply0", got_q[0], 8'h3C);
      check("b2b_reply1", got_q[1], 8'hC3);
    end
    check("b2b_cs_gap_ok", (last_gap >= CD + 1), 1);
    recv_rdy = 1'b0;
    wait_send_rdy(n);

    // Reset on the 5th sclk rising edge of a transfer.
    mode     = M_LOOP;
    send_msg = 8'hFF;
    send_val = 1'b1;
    tick();
    send_val = 1'b0;
    rises = 0;
    prev  = sclk;
    for (int i = 0; i < 200 && rises < 5; i++) begin
      tick();
      if (sclk && !prev) rises++;
      prev = sclk;
    end
    check("midrst_reached_5th_rise", rises, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_cs", cs, 1);
    check("midrst_sclk", sclk, 0);
    check("midrst_mosi", mosi, 0);
    check("midrst_recv_val", recv_val, 0);
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (recv_val || !cs) quiet = 1'b0;
    end
    check("midrst_no_reply", quiet, 1);
    v = '{msg: 8'h5A, mode: M_LOOP, word: 8'h00, hold: 1, exp_reply: 8'h5A};
    do_txn(v, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Clocked SPI initiator (mode 0, MSB first) that drives cs/sclk/mosi and samples miso, one fixed-length packet per transaction.
- Partner of the SPI minion inside the interconnect: lets an FPGA harness or a test SoC push packets into the minion and collect its replies.
- Stream side uses val/rdy handshakes (send = request in, recv = reply out); full-duplex, one reply per request.

Parameters:
- NBITS, 20, packet width in bits (>=1)
- CLK_DIV, 4, clk cycles per sclk half-period (>=1)

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- send_val  input  1  request packet valid
- send_rdy  output  1  master can accept a request
- send_msg  input  NBITS  request packet, bit NBITS-1 sent first
- recv_val  output  1  reply packet valid
- recv_rdy  input  1  consumer accepts reply
- recv_msg  output  NBITS  reply packet, first miso bit in bit NBITS-1
- cs  output  1  chip select, active low
- sclk  output  1  serial clock, idle low
- mosi  output  1  serial data to minion
- miso  input  1  serial data from minion

Behaviour:
- All outputs registered. Reset values: cs=1, sclk=0, mosi=0, send_rdy=0, recv_val=0, recv_msg=0.
- FSM states: GAP, IDLE, SETUP, HIGH, LOW, DONE. Reset enters GAP.
- GAP: cs=1, sclk=0, send_rdy=0. Stays CLK_DIV cycles, then goes to IDLE. This guarantees cs is high for at least CLK_DIV+1 cycles between packets.
- IDLE: send_rdy=1. On send_val&&send_rdy: load tx shift reg with send_msg, set bit counter to NBITS, go SETUP.
- SETUP: cs=0, sclk=0, mosi=tx[NBITS-1]. Stays CLK_DIV cycles, then goes to HIGH.
- HIGH: sclk=1, mosi held stable. On the edge that ends the phase (after CLK_DIV cycles):
  - rx <= {rx[NBITS-2:0], miso}
  - tx shifts left, zero-filled
  - counter decrements
  - go LOW
- LOW: sclk=0, mosi=tx[NBITS-1]. After CLK_DIV cycles: go HIGH if counter!=0, else DONE. The final LOW is the cs hold time, with mosi=0.
- DONE: cs=1, recv_val=1, recv_msg=rx. Hold until recv_rdy, then go GAP.
  - recv_msg stays stable while recv_val=1 and recv_rdy=0.
  - recv_val drops on the cycle after acceptance.
- Timing per packet:
  - cs low for exactly CLK_DIV*(2*NBITS+1) cycles.
  - Exactly NBITS sclk rising edges.
  - recv_val rises on the same cycle cs rises.
- send_rdy=0 in every state except IDLE. No request is accepted mid-transfer or while a reply is unconsumed.
- miso is sampled only at the end of a HIGH phase. This leaves slack for minion-side synchronizers, since the minion updates miso after the falling edge.
- Counters: phase counter $clog2(CLK_DIV+1) bits, bit counter $clog2(NBITS+1) bits. Neither wraps; both reload on every phase or packet start.
- Reset mid-transfer: next cycle cs=1, sclk=0, mosi=0, recv_val=0, state GAP. The partial packet is discarded and no reply is produced.
- send_val asserted during reset has no effect. send_msg is ignored except on the accept edge.

Optional Feature:
- Macro: SPI_MASTER_CTRL_PARITY_EN.
- Defined: adds output recv_parity (1 bit), valid with recv_val, equal to the XOR reduction of recv_msg.
  - Registered when entering DONE.
  - Reset value 0.
  - Used to cross-check against the interconnect's minion_parity pin.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Loopback (miso=mosi), NBITS=8, CLK_DIV=2, send 0xA5:
  - cs low for exactly 34 cycles, 8 sclk pulses each 2 cycles high.
  - mosi sequence 1,0,1,0,0,1,0,1.
  - recv_msg=0xA5 with recv_val rising the same cycle cs rises.
- miso tied 1, send 0x00: recv_msg=0xFF and mosi stays 0 throughout. miso tied 0, send 0xFF: recv_msg=0x00.
- Backpressure: hold recv_rdy=0 for 10 cycles after recv_val:
  - recv_val and recv_msg stay stable, send_rdy=0, cs=1, no sclk edges.
  - After accept, send_rdy returns 1 after CLK_DIV+1 cycles.
- Back-to-back: send_val held high with 0x3C then 0xC3, recv_rdy=1:
  - two transactions, cs high >= CLK_DIV+1 cycles between them.
  - loopback replies 0x3C then 0xC3, in order.
- Reset asserted on the 5th sclk rising edge of a transfer:
  - next cycle cs=1, sclk=0, mosi=0, recv_val=0.
  - a fresh 0x5A transfer afterwards returns 0x5A in loopback.
- With SPI_MASTER_CTRL_PARITY_EN, loopback 0x07 -> recv_parity=1; 0x03 -> recv_parity=0.
